// File: rtl/sram_1rw1r_wmask_param_if.sv
// Port-0 (read/write, masked) and port-1 (read-only) signal bundle for the drive-circuit SRAM.
interface sram_1rw1r_wmask_param_if #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned WMASK_WIDTH = 2
);
    logic                   csb0;
    logic                   web0;
    logic [WMASK_WIDTH-1:0] wmask0;
    logic [ADDR_WIDTH-1:0]  addr0;
    logic [DATA_WIDTH-1:0]  din0;
    logic [DATA_WIDTH-1:0]  dout0;
    logic                   dout0_valid;
    logic                   csb1;
    logic [ADDR_WIDTH-1:0]  addr1;
    logic [DATA_WIDTH-1:0]  dout1;
    logic                   dout1_valid;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, dout1, dout1_valid
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, dout1, dout1_valid
    );
endinterface

// File: rtl/sram_1rw1r_wmask_param.sv
// Behavioural 1RW+1R SRAM with per-segment write mask, configurable read latency and a
// selectable port-1/port-0 same-address collision policy.
module sram_1rw1r_wmask_param #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned WMASK_WIDTH  = 2,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          WRITE_FIRST  = 1'b0,
    parameter bit          INIT_ZERO    = 1'b0
) (
    input logic                    clk0,
    input logic                    rst0,
    sram_1rw1r_wmask_param_if.slave bus
);
    localparam int unsigned RamDepth = 1 << ADDR_WIDTH;
    localparam int unsigned Seg      = DATA_WIDTH / WMASK_WIDTH;
    // Clamp so an illegal latency still elaborates far enough to report the error.
    localparam int unsigned Lat = (READ_LATENCY >= 1 && READ_LATENCY <= 4) ? READ_LATENCY : 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("sram_1rw1r_wmask_param: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("sram_1rw1r_wmask_param: DATA_WIDTH must be divisible by WMASK_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [RamDepth];

    if (INIT_ZERO) begin : g_init_zero
        initial begin
            for (int unsigned i = 0; i < RamDepth; i++) mem[i] = '0;
        end
    end

    logic [DATA_WIDTH-1:0] bit_mask;
    for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_mask
        assign bit_mask[i*Seg +: Seg] = {Seg{bus.wmask0[i]}};
    end

    logic wr_en, rd0_en, rd1_en, collide;
    logic [DATA_WIDTH-1:0] rd0_data, rd1_data, merged;

    assign wr_en   = !rst0 && !bus.csb0 && !bus.web0;
    assign rd0_en  = !rst0 && !bus.csb0 && bus.web0;
    assign rd1_en  = !rst0 && !bus.csb1;
    assign collide = wr_en && (bus.addr1 == bus.addr0);
    assign merged  = (mem[bus.addr0] & ~bit_mask) | (bus.din0 & bit_mask);

    always_comb begin
        rd0_data = mem[bus.addr0];
        rd1_data = mem[bus.addr1];
        if (WRITE_FIRST && collide) rd1_data = merged;
    end

    always_ff @(posedge clk0) begin
        if (wr_en) mem[bus.addr0] <= merged;
    end

    logic [DATA_WIDTH-1:0] pipe0_q [Lat];
    logic [DATA_WIDTH-1:0] pipe1_q [Lat];
    logic [Lat-1:0]        vld0_q, vld1_q;
    logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
    logic                  dout0_vld_q, dout1_vld_q;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            for (int unsigned k = 0; k < Lat; k++) begin
                pipe0_q[k] <= '0;
                pipe1_q[k] <= '0;
            end
            vld0_q      <= '0;
            vld1_q      <= '0;
            dout0_q     <= '0;
            dout1_q     <= '0;
            dout0_vld_q <= 1'b0;
            dout1_vld_q <= 1'b0;
        end else begin
            pipe0_q[0] <= rd0_data;
            pipe1_q[0] <= rd1_data;
            vld0_q[0]  <= rd0_en;
            vld1_q[0]  <= rd1_en;
            for (int unsigned k = 1; k < Lat; k++) begin
                pipe0_q[k] <= pipe0_q[k-1];
                pipe1_q[k] <= pipe1_q[k-1];
                vld0_q[k]  <= vld0_q[k-1];
                vld1_q[k]  <= vld1_q[k-1];
            end
            // Outputs hold their last result between valid pulses.
            dout0_vld_q <= vld0_q[Lat-1];
            dout1_vld_q <= vld1_q[Lat-1];
            if (vld0_q[Lat-1]) dout0_q <= pipe0_q[Lat-1];
            if (vld1_q[Lat-1]) dout1_q <= pipe1_q[Lat-1];
        end
    end

    assign bus.dout0       = dout0_q;
    assign bus.dout1       = dout1_q;
    assign bus.dout0_valid = dout0_vld_q;
    assign bus.dout1_valid = dout1_vld_q;
endmodule

// File: tb/tb_sram_1rw1r_wmask_param.sv
// Drives three SRAM configurations with shared stimulus and checks them against a read-schedule
// model, a directed vector table and hand-written latency/collision/reset sequences.
module tb_sram_1rw1r_wmask_param;
    localparam int NDut = 3;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic        rst0;
    logic        csb0, web0, csb1;
    logic [1:0]  wmask0;
    logic [10:0] addr0, addr1;
    logic [15:0] din0;

    sram_1rw1r_wmask_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WMASK_WIDTH(2)) if_a ();
    sram_1rw1r_wmask_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WMASK_WIDTH(2)) if_b ();
    sram_1rw1r_wmask_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .WMASK_WIDTH(2)) if_c ();

    assign if_a.csb0 = csb0;  assign if_a.web0 = web0;  assign if_a.wmask0 = wmask0;
    assign if_a.addr0 = addr0; assign if_a.din0 = din0; assign if_a.csb1 = csb1;
    assign if_a.addr1 = addr1;
    assign if_b.csb0 = csb0;  assign if_b.web0 = web0;  assign if_b.wmask0 = wmask0;
    assign if_b.addr0 = addr0; assign if_b.din0 = din0; assign if_b.csb1 = csb1;
    assign if_b.addr1 = addr1;
    assign if_c.csb0 = csb0;  assign if_c.web0 = web0;  assign if_c.wmask0 = wmask0;
    assign if_c.addr0 = addr0; assign if_c.din0 = din0; assign if_c.csb1 = csb1;
    assign if_c.addr1 = addr1;

    sram_1rw1r_wmask_param #(.READ_LATENCY(1), .WRITE_FIRST(1'b0), .INIT_ZERO(1'b1)) u_a (
        .clk0(clk0), .rst0(rst0), .bus(if_a)
    );
    sram_1rw1r_wmask_param #(.READ_LATENCY(3), .WRITE_FIRST(1'b1), .INIT_ZERO(1'b1)) u_b (
        .clk0(clk0), .rst0(rst0), .bus(if_b)
    );
    sram_1rw1r_wmask_param #(.READ_LATENCY(2), .WRITE_FIRST(1'b0), .INIT_ZERO(1'b1)) u_c (
        .clk0(clk0), .rst0(rst0), .bus(if_c)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference: flat memory plus, per DUT, a table of results scheduled for future edges.
    int          lat [NDut];
    bit          wf  [NDut];
    logic [15:0] mem_m [2048];
    bit          sv0 [NDut][8];
    bit          sv1 [NDut][8];
    logic [15:0] sd0 [NDut][8];
    logic [15:0] sd1 [NDut][8];
    logic [15:0] ed0 [NDut];
    logic [15:0] ed1 [NDut];
    bit          ev0 [NDut];
    bit          ev1 [NDut];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void model_edge();
        logic [15:0] bm, r1;
        int slot;
        for (int d = 0; d < NDut; d++) begin
            ev0[d] = 1'b0;
            ev1[d] = 1'b0;
        end
        if (rst0) begin
            for (int d = 0; d < NDut; d++) begin
                for (int s = 0; s < 8; s++) begin
                    sv0[d][s] = 1'b0;
                    sv1[d][s] = 1'b0;
                end
                ed0[d] = '0;
                ed1[d] = '0;
            end
            return;
        end
        for (int d = 0; d < NDut; d++) begin
            slot = cyc % 8;
            if (sv0[d][slot]) begin ed0[d] = sd0[d][slot]; ev0[d] = 1'b1; sv0[d][slot] = 1'b0; end
            if (sv1[d][slot]) begin ed1[d] = sd1[d][slot]; ev1[d] = 1'b1; sv1[d][slot] = 1'b0; end
        end
        bm = {{8{wmask0[1]}}, {8{wmask0[0]}}};
        for (int d = 0; d < NDut; d++) begin
            slot = (cyc + lat[d]) % 8;
            if (!csb0 && web0) begin sv0[d][slot] = 1'b1; sd0[d][slot] = mem_m[addr0]; end
            if (!csb1) begin
                r1 = mem_m[addr1];
                if (wf[d] && !csb0 && !web0 && addr1 == addr0) r1 = (r1 & ~bm) | (din0 & bm);
                sv1[d][slot] = 1'b1;
                sd1[d][slot] = r1;
            end
        end
        if (!csb0 && !web0) mem_m[addr0] = (mem_m[addr0] & ~bm) | (din0 & bm);
    endfunction

    task automatic check_dut(input int d, input string nm, input logic [15:0] o0, input logic v0,
                             input logic [15:0] o1, input logic v1);
        chk($sformatf("%s.dout0@%0d", nm, cyc), o0, ed0[d]);
        chk($sformatf("%s.dout0_valid@%0d", nm, cyc), 16'(v0), 16'(ev0[d]));
        chk($sformatf("%s.dout1@%0d", nm, cyc), o1, ed1[d]);
        chk($sformatf("%s.dout1_valid@%0d", nm, cyc), 16'(v1), 16'(ev1[d]));
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
        cyc++;
        model_edge();
        check_dut(0, "a", if_a.dout0, if_a.dout0_valid, if_a.dout1, if_a.dout1_valid);
        check_dut(1, "b", if_b.dout0, if_b.dout0_valid, if_b.dout1, if_b.dout1_valid);
        check_dut(2, "c", if_c.dout0, if_c.dout0_valid, if_c.dout1, if_c.dout1_valid);
    endtask

    task automatic set_idle();
        rst0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
        csb1 = 1'b1; addr1 = '0;
    endtask
    task automatic set_wr(input logic [10:0] a, input logic [15:0] d, input logic [1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask
    task automatic set_rd1(input logic [10:0] a);
        csb1 = 1'b0; addr1 = a;
    endtask

    typedef struct {
        bit rst; bit csb0; bit web0; logic [1:0] wm; logic [10:0] a0; logic [15:0] d0;
        bit csb1; logic [10:0] a1;
        logic [15:0] e0; bit v0; logic [15:0] e1; bit v1;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit c0, input bit w0, input logic [1:0] m,
                                input logic [10:0] a0, input logic [15:0] d0, input bit c1,
                                input logic [10:0] a1, input logic [15:0] e0, input bit v0,
                                input logic [15:0] e1, input bit v1);
        vec_t v;
        v.rst = r; v.csb0 = c0; v.web0 = w0; v.wm = m; v.a0 = a0; v.d0 = d0;
        v.csb1 = c1; v.a1 = a1; v.e0 = e0; v.v0 = v0; v.e1 = e1; v.v1 = v1;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        lat[0] = 1; lat[1] = 3; lat[2] = 2;
        wf[0]  = 1'b0; wf[1] = 1'b1; wf[2] = 1'b0;
        for (int i = 0; i < 2048; i++) mem_m[i] = '0;
        for (int d = 0; d < NDut; d++) begin
            ed0[d] = '0; ed1[d] = '0; ev0[d] = 1'b0; ev1[d] = 1'b0;
            for (int s = 0; s < 8; s++) begin sv0[d][s] = 1'b0; sv1[d][s] = 1'b0; end
        end

        // Expected outputs below are for instance a (latency 1, read-old collision policy).
        vecs.push_back(mk(1, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(1, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 5, 16'hABCD, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 2'b01, 5, 16'h1234, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, 5, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'hAB34, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'hAB34, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 7, 16'hFFFF, 1, 0, 16'hAB34, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 2'b10, 7, 16'h0000, 0, 7, 16'hAB34, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 0, 7, 16'hAB34, 0, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'hAB34, 0, 16'h00FF, 1));
        vecs.push_back(mk(0, 0, 0, 2'b11, 4, 16'hCAFE, 1, 0, 16'hAB34, 0, 16'h00FF, 0));
        vecs.push_back(mk(0, 0, 0, 2'b11, 3, 16'hBEEF, 0, 4, 16'hAB34, 0, 16'h00FF, 0));
        vecs.push_back(mk(0, 0, 1, 2'b00, 7, 16'h0000, 0, 3, 16'hAB34, 0, 16'hCAFE, 1));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'h00FF, 1, 16'hBEEF, 1));
        vecs.push_back(mk(0, 1, 1, 2'b00, 0, 16'h0000, 1, 0, 16'h00FF, 0, 16'hBEEF, 0));

        foreach (vecs[i]) begin
            rst0 = vecs[i].rst; csb0 = vecs[i].csb0; web0 = vecs[i].web0; wmask0 = vecs[i].wm;
            addr0 = vecs[i].a0; din0 = vecs[i].d0; csb1 = vecs[i].csb1; addr1 = vecs[i].a1;
            tick();
            chk($sformatf("tbl[%0d].dout0", i), if_a.dout0, vecs[i].e0);
            chk($sformatf("tbl[%0d].dout0_valid", i), 16'(if_a.dout0_valid), 16'(vecs[i].v0));
            chk($sformatf("tbl[%0d].dout1", i), if_a.dout1, vecs[i].e1);
            chk($sformatf("tbl[%0d].dout1_valid", i), 16'(if_a.dout1_valid), 16'(vecs[i].v1));
        end

        // Collision under the write-first policy (b) and read-old policy (c).
        set_idle(); set_wr(7, 16'hFFFF, 2'b11); tick();
        set_idle(); set_wr(7, 16'h0000, 2'b10); set_rd1(7); tick();
        set_idle(); set_rd1(7); tick();
        set_idle(); tick();
        chk("col.c.dout1", if_c.dout1, 16'hFFFF);
        chk("col.c.dout1_valid", 16'(if_c.dout1_valid), 16'd1);
        tick();
        chk("col.b.dout1_first", if_b.dout1, 16'h00FF);
        chk("col.c.dout1_next", if_c.dout1, 16'h00FF);
        tick();
        chk("col.b.dout1_next", if_b.dout1, 16'h00FF);
        chk("col.b.dout1_valid", 16'(if_b.dout1_valid), 16'd1);
        tick();
        chk("col.b.dout1_valid_end", 16'(if_b.dout1_valid), 16'd0);

        // Four back-to-back port-1 reads through the three-stage pipeline of b.
        for (int a = 1; a <= 4; a++) begin
            set_idle(); set_wr(11'(a), 16'(16'h0011 * a), 2'b11); tick();
        end
        for (int k = 0; k < 9; k++) begin
            set_idle();
            if (k < 4) set_rd1(11'(k + 1));
            tick();
            chk($sformatf("pipe.b.valid[%0d]", k), 16'(if_b.dout1_valid),
                16'((k >= 3 && k <= 6) ? 1 : 0));
            if (k >= 3 && k <= 6)
                chk($sformatf("pipe.b.dout1[%0d]", k), if_b.dout1, 16'(16'h0011 * (k - 2)));
        end

        // Reset while a read is in flight on c; a write during reset must be ignored.
        set_idle(); set_wr(9, 16'h5A5A, 2'b11); tick();
        set_idle(); set_rd1(9); tick();
        set_idle(); set_wr(9, 16'h0000, 2'b11); rst0 = 1'b1; tick();
        chk("rst.c.dout1", if_c.dout1, 16'h0000);
        chk("rst.c.valid", 16'(if_c.dout1_valid), 16'd0);
        set_idle(); tick();
        chk("rst.c.dout1_after", if_c.dout1, 16'h0000);
        chk("rst.c.valid_after", 16'(if_c.dout1_valid), 16'd0);
        set_rd1(9); tick();
        set_idle(); tick();
        tick();
        chk("rst.c.mem_kept", if_c.dout1, 16'h5A5A);
        chk("rst.c.valid_kept", 16'(if_c.dout1_valid), 16'd1);

        // Random traffic, biased to a small address window so collisions are frequent.
        for (int n = 0; n < 2000; n++) begin
            rst0   = ($urandom_range(0, 63) == 0);
            csb0   = ($urandom_range(0, 3) == 0);
            web0   = 1'($urandom_range(0, 1));
            wmask0 = 2'($urandom);
            addr0  = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
            din0   = 16'($urandom);
            csb1   = ($urandom_range(0, 3) == 0);
            addr1  = ($urandom_range(0, 2) == 0) ? addr0 : 11'($urandom_range(0, 15));
            tick();
        end
        set_idle();
        for (int n = 0; n < 5; n++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
